serial_adder: RTL and testbench
===============================

// Module: serial_adder
// PURPOSE
//  - Bit-serial N-bit adder: parallel-load two operands, add LSB-first one bit per clock through a single
//    full-adder cell, present the parallel sum plus carry when finished.
//  - Arithmetic counterpart to the combinational half subtractor; area-lean datapath for slow arithmetic paths.
// PARAMETERS
//  - WIDTH  default 8  operand/result width in bits; legal range WIDTH >= 2
// PORTS
//  - Clock_In    input   1      single clock, all state on rising edge
//  - Reset_N_In  input   1      asynchronous, active-low reset
//  - Start_In    input   1      request; accepted only in IDLE
//  - Data_A_In   input   WIDTH  operand A, sampled on the accepted Start_In edge
//  - Data_B_In   input   WIDTH  operand B, sampled on the accepted Start_In edge
//  - Sub_In      input   1      present only with SERIAL_ADDER_SUB_EN; 1 = compute A-B, sampled with operands
//  - Busy_Out    output  1      high in SHIFT and DONE
//  - Done_Out    output  1      one-cycle pulse in DONE; Sum_Out/Carry_Out valid from this cycle
//  - Sum_Out     output  WIDTH  result, held until the next accepted start
//  - Carry_Out   output  1      final carry out (borrow in subtract mode, see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async assert, sync release): state IDLE; Busy_Out, Done_Out, Sum_Out, Carry_Out, carry reg and bit counter all 0.
//  - FSM: IDLE --Start_In--> SHIFT --(counter == WIDTH-1)--> DONE --(always)--> IDLE.
//  - IDLE: on Start_In=1, latch A, B (and Sub); load carry reg with 0 (Sub in subtract mode); clear counter.
//  - SHIFT: each cycle feed A[0], B[0] (B[0] inverted if subtracting) and carry reg into full_adder_cell;
//    shift the sum bit into the result register from the MSB end; shift A and B right by 1; update carry reg;
//    increment the counter.
//  - Counter width $clog2(WIDTH); exactly WIDTH SHIFT cycles.
//  - Latency: Start_In high at edge k -> Done_Out high in cycle k+WIDTH+1.
//  - Sum_Out/Carry_Out update only on the DONE transition; Sum_Out never shows partial results.
//  - Arithmetic is modulo 2^WIDTH; overflow is visible only on Carry_Out.
//  - Start_In during SHIFT or DONE: ignored; not queued, no effect on the operation in flight.
//  - Start_In held high continuously: a new operation is accepted on every return to IDLE.
//  - Operands may change freely after acceptance without affecting the result.
//  - Reset mid-operation: aborts at once, all outputs 0, no Done_Out pulse; the next Start_In after release
//    runs normally.
// CONFIGURATION
//  - Macro SERIAL_ADDER_SUB_EN defined: Sub_In port exists.
//    - Sub=1 computes A + ~B + 1.
//    - Carry_Out = ~final_carry (1 = borrow, i.e. A < B unsigned).
//    - Sub=0 is identical to plain add.
//  - Macro not defined: no Sub_In port; adder only; Carry_Out = final carry.
// STRUCTURE
//  - Package serial_adder_pkg:
//    - typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} sa_state_t
//    - localparam int SA_DEFAULT_WIDTH = 8
//  - Sub-module full_adder_cell (a, b, cin -> sum, cout), purely combinational, instantiated once.
//  - serial_adder holds the FSM, counter, operand shift registers, carry reg and result register.
// TESTING
//  - WIDTH=8, A=8'h0F, B=8'h01, Start 1 cycle -> Done_Out pulses in cycle 9 only; Sum_Out=8'h10, Carry_Out=0.
//  - A=8'hFF, B=8'h01 -> Sum_Out=8'h00, Carry_Out=1; Busy_Out high for exactly 9 cycles.
//  - Start A=3, B=4, then pulse Start with A=8'hAA during SHIFT -> Sum_Out=8'h07, exactly one Done_Out.
//  - Reset_N_In low at 4th SHIFT cycle -> Busy/Done/Sum/Carry 0 immediately, no Done_Out;
//    after release A=2, B=2 -> Sum_Out=8'h04.
//  - SERIAL_ADDER_SUB_EN: Sub=1, A=5, B=7 -> Sum_Out=8'hFE, Carry_Out=1; A=7, B=5 -> 8'h02, Carry_Out=0.
//  - 200 random back-to-back ops (Start held high) -> every result matches {carry,sum} = A+B (or A-B).

Source files
------------

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared state encoding and default width for the bit-serial adder.
package serial_adder_pkg;
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} sa_state_t;
    localparam int SA_DEFAULT_WIDTH = 8;
endpackage

// File: rtl/serial_adder_full_adder_cell.sv
// full_adder_cell: single-bit combinational full adder used by the serial datapath.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_adder.sv
// serial_adder: LSB-first bit-serial adder, one full-adder cell, WIDTH cycles per operation.
// Define SERIAL_ADDER_SUB_EN to add the Sub_In port and A-B (borrow on Carry_Out) support.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = SA_DEFAULT_WIDTH
) (
    input  logic             Clock_In,
    input  logic             Reset_N_In,
    input  logic             Start_In,
    input  logic [WIDTH-1:0] Data_A_In,
    input  logic [WIDTH-1:0] Data_B_In,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             Sub_In,
`endif
    output logic             Busy_Out,
    output logic             Done_Out,
    output logic [WIDTH-1:0] Sum_Out,
    output logic             Carry_Out
);
    localparam int CW = $clog2(WIDTH);

    sa_state_t        state;
    logic [WIDTH-1:0] a_q, b_q, res_q, res_next;
    logic [CW-1:0]    cnt;
    logic             carry_q, sub_q, sub_req, fa_sum, fa_cout;

`ifdef SERIAL_ADDER_SUB_EN
    assign sub_req = Sub_In;
`else
    assign sub_req = 1'b0;
    assign sub_q   = 1'b0;
`endif

    // Subtraction reuses the adder as A + ~B + 1, the +1 coming from the preloaded carry.
    full_adder_cell u_fa (
        .a   (a_q[0]),
        .b   (b_q[0] ^ sub_q),
        .cin (carry_q),
        .sum (fa_sum),
        .cout(fa_cout)
    );

    assign res_next = {fa_sum, res_q[WIDTH-1:1]};

    always_ff @(posedge Clock_In or negedge Reset_N_In) begin
        if (!Reset_N_In) begin
            state     <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            cnt       <= '0;
            carry_q   <= 1'b0;
            Busy_Out  <= 1'b0;
            Done_Out  <= 1'b0;
            Sum_Out   <= '0;
            Carry_Out <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
            sub_q     <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    Done_Out <= 1'b0;
                    if (Start_In) begin
                        a_q      <= Data_A_In;
                        b_q      <= Data_B_In;
                        carry_q  <= sub_req;
                        cnt      <= '0;
                        Busy_Out <= 1'b1;
                        state    <= S_SHIFT;
`ifdef SERIAL_ADDER_SUB_EN
                        sub_q    <= Sub_In;
`endif
                    end
                end
                S_SHIFT: begin
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    res_q   <= res_next;
                    carry_q <= fa_cout;
                    cnt     <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        state     <= S_DONE;
                        Done_Out  <= 1'b1;
                        Sum_Out   <= res_next;
                        Carry_Out <= fa_cout ^ sub_q;
                    end
                end
                S_DONE: begin
                    Done_Out <= 1'b0;
                    Busy_Out <= 1'b0;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: randomized self-checking bench for serial_adder against an arithmetic model.
module tb_serial_adder;
    localparam int W = 8;

    logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0, sub = 1'b0;
    logic [W-1:0] da = '0, db = '0;
    logic         busy, done, cy;
    logic [W-1:0] sum;
    int           errors = 0, checks = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(W)) dut (
        .Clock_In  (clk),
        .Reset_N_In(rst_n),
        .Start_In  (start),
        .Data_A_In (da),
        .Data_B_In (db),
`ifdef SERIAL_ADDER_SUB_EN
        .Sub_In    (sub),
`endif
        .Busy_Out  (busy),
        .Done_Out  (done),
        .Sum_Out   (sum),
        .Carry_Out (cy)
    );

    // Reference: plain arithmetic; carry is the 2^W bit for add, the borrow for subtract.
    function automatic logic [W:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        logic [W:0] r;
        if (s) begin
            r[W-1:0] = a - b;
            r[W]     = (a < b);
        end else begin
            r = {1'b0, a} + {1'b0, b};
        end
        return r;
    endfunction

    function automatic logic rand_sub();
`ifdef SERIAL_ADDER_SUB_EN
        return 1'($urandom_range(0, 1));
`else
        return 1'b0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one operation and observes 14 cycles after the accepting edge.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input int pulse_at,
                         output int lat, output int dcnt, output int bcnt, output logic [W:0] res);
        da = a; db = b; sub = s; start = 1'b1;
        tick();
        start = 1'b0;
        lat = -1; dcnt = 0; bcnt = 0; res = '0;
        for (int i = 0; i < 14; i++) begin
            if (busy) bcnt++;
            if (done) begin
                dcnt++;
                if (lat < 0) begin
                    lat = i;
                    res = {cy, sum};
                end
            end
            if (i == 0) begin
                da = W'($urandom);
                db = W'($urandom);
                sub = rand_sub();
            end
            if (i == pulse_at) begin
                start = 1'b1;
                da = 8'hAA;
            end else if (i == pulse_at + 1) begin
                start = 1'b0;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        #2;
        checks += 4;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        if (sum !== '0) begin errors++; $display("FAIL reset_sum got=%h exp=00", sum); end
        if (cy !== 1'b0) begin errors++; $display("FAIL reset_carry got=%b exp=0", cy); end
        tick(); tick();
        rst_n = 1'b1;
        tick();
        checks += 2;
        if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got=%b exp=0", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL idle_done got=%b exp=0", done); end
    endtask

    task automatic test_basic(input string nm, input logic [W-1:0] a, input logic [W-1:0] b);
        int lat, dcnt, bcnt;
        logic [W:0] res, exp;
        exp = ref_op(a, b, 1'b0);
        do_op(a, b, 1'b0, -1, lat, dcnt, bcnt, res);
        checks += 4;
        if (lat != W) begin errors++; $display("FAIL %s_latency got=%0d exp=%0d", nm, lat, W); end
        if (dcnt != 1) begin errors++; $display("FAIL %s_done_count got=%0d exp=1", nm, dcnt); end
        if (bcnt != W + 1) begin errors++; $display("FAIL %s_busy_cycles got=%0d exp=%0d", nm, bcnt, W + 1); end
        if (res !== exp) begin errors++; $display("FAIL %s_result got=%h exp=%h", nm, res, exp); end
        checks++;
        if ({cy, sum} !== exp) begin errors++; $display("FAIL %s_hold got=%h exp=%h", nm, {cy, sum}, exp); end
    endtask

    task automatic test_ignore_start();
        int lat, dcnt, bcnt;
        logic [W:0] res;
        do_op(8'h03, 8'h04, 1'b0, 2, lat, dcnt, bcnt, res);
        checks += 3;
        if (res !== 9'h007) begin errors++; $display("FAIL ignore_result got=%h exp=007", res); end
        if (dcnt != 1) begin errors++; $display("FAIL ignore_done_count got=%0d exp=1", dcnt); end
        if (lat != W) begin errors++; $display("FAIL ignore_latency got=%0d exp=%0d", lat, W); end
    endtask

    task automatic test_reset_mid();
        int lat, dcnt, bcnt, seen;
        logic [W:0] res;
        da = 8'h55; db = 8'h11; sub = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        rst_n = 1'b0;
        #1;
        checks += 4;
        if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL midrst_done got=%b exp=0", done); end
        if (sum !== '0) begin errors++; $display("FAIL midrst_sum got=%h exp=00", sum); end
        if (cy !== 1'b0) begin errors++; $display("FAIL midrst_carry got=%b exp=0", cy); end
        tick(); tick();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL midrst_no_done got=%0d exp=0", seen); end
        do_op(8'h02, 8'h02, 1'b0, -1, lat, dcnt, bcnt, res);
        checks += 2;
        if (res !== 9'h004) begin errors++; $display("FAIL midrst_after got=%h exp=004", res); end
        if (dcnt != 1) begin errors++; $display("FAIL midrst_after_done got=%0d exp=1", dcnt); end
    endtask

    task automatic test_sub();
`ifdef SERIAL_ADDER_SUB_EN
        int lat, dcnt, bcnt;
        logic [W:0] res;
        do_op(8'h05, 8'h07, 1'b1, -1, lat, dcnt, bcnt, res);
        checks++;
        if (res !== 9'h1FE) begin errors++; $display("FAIL sub_5_7 got=%h exp=1fe", res); end
        do_op(8'h07, 8'h05, 1'b1, -1, lat, dcnt, bcnt, res);
        checks++;
        if (res !== 9'h002) begin errors++; $display("FAIL sub_7_5 got=%h exp=002", res); end
        do_op(8'h07, 8'h05, 1'b0, -1, lat, dcnt, bcnt, res);
        checks++;
        if (res !== 9'h00C) begin errors++; $display("FAIL sub0_add got=%h exp=00c", res); end
`endif
    endtask

    task automatic test_back_to_back();
        logic [W:0] q[$];
        logic [W:0] exp;
        int got = 0, last = -1, cyc = 0;
        da = W'($urandom); db = W'($urandom); sub = rand_sub();
        q.push_back(ref_op(da, db, sub));
        start = 1'b1;
        while (got < 200 && cyc < 3000) begin
            tick();
            cyc++;
            if (done) begin
                exp = (q.size() > 0) ? q.pop_front() : '0;
                checks++;
                if ({cy, sum} !== exp) begin
                    errors++;
                    $display("FAIL b2b_result op=%0d got=%h exp=%h", got, {cy, sum}, exp);
                end
                if (last >= 0) begin
                    checks++;
                    if (cyc - last != W + 2) begin
                        errors++;
                        $display("FAIL b2b_interval op=%0d got=%0d exp=%0d", got, cyc - last, W + 2);
                    end
                end
                last = cyc;
                got++;
                da = W'($urandom); db = W'($urandom); sub = rand_sub();
                q.push_back(ref_op(da, db, sub));
            end
        end
        start = 1'b0;
        checks++;
        if (got != 200) begin errors++; $display("FAIL b2b_timeout got=%0d exp=200", got); end
        tick(); tick(); tick();
    endtask

    initial begin
        test_reset();
        test_basic("add_0f_01", 8'h0F, 8'h01);
        test_basic("add_ff_01", 8'hFF, 8'h01);
        test_basic("add_rand", W'($urandom), W'($urandom));
        test_ignore_start();
        test_reset_mid();
        test_sub();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
